rep_monitor: RTL

Parametrised multi-channel repetition monitor for the SVA tutorial testbenches. It counts occurrences of a per-channel event bit `a` and flags when the count falls within a `[MIN_REP:MAX_REP]` range. Two modes are provided:
- **consecutive-run mode**: SVA `[*MIN:MAX]` semantics.
- **framed-window mode**: SVA `[=MIN:MAX]` semantics, counted between explicit frame markers.

It sits beside the property under test as a synthesizable cover/assume helper, with one instance serving `N_CH` independent channels.

---
 rtl/rep_monitor_pkg.sv | 21 ++
 rtl/rep_monitor_ch.sv | 134 +++++++++++++
 rtl/rep_monitor.sv | 44 ++++
 3 files changed

// File: rtl/rep_monitor_pkg.sv
// Shared types and helpers for the multi-channel repetition monitor.
package rep_monitor_pkg;

    // Per-channel counting mode: SVA [*MIN:MAX] runs or [=MIN:MAX] within frames.
    typedef enum logic {
        MODE_CONSEC = 1'b0,
        MODE_FRAMED = 1'b1
    } mode_e;

    // Frame tracking state, only meaningful in framed mode.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } frame_state_e;

    // Counter width able to hold the saturation value MAX_REP+1.
    function automatic int cnt_width(input int max_rep);
        return $clog2(max_rep + 2);
    endfunction

endpackage

// File: rtl/rep_monitor_ch.sv
// One channel of the repetition monitor: saturating hit counter, frame FSM
// and registered match/fail/err pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame open; consecutive mode always sits here
// ST_OPEN | framed mode, frame_start seen, counting hits until frame_end
module rep_monitor_ch
    import rep_monitor_pkg::*;
#(
    parameter int MIN_REP = 5,
    parameter int MAX_REP = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_we,
    input  logic cfg_mode,
    input  logic a,
    input  logic frame_start,
    input  logic frame_end,
    output logic match,
    output logic fail,
    output logic err
);

    localparam int CNT_W = cnt_width(MAX_REP);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_REP);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_REP);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_REP + 1);

    mode_e              mode_q, mode_d;
    frame_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   cnt_a;
    logic               match_d, fail_d, err_d;

    function automatic logic in_range(input logic [CNT_W-1:0] c);
        return (c >= CNT_MIN) && (c <= CNT_MAX);
    endfunction

    // Count including this cycle's hit; sticks at MAX_REP+1 so it never wraps.
    assign cnt_inc = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(a);
    // Count of a frame that starts this cycle.
    assign cnt_a   = CNT_W'(a);

    // State, counter and output pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_CONSEC;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            match   <= 1'b0;
            fail    <= 1'b0;
            err     <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match   <= match_d;
            fail    <= fail_d;
            err     <= err_d;
        end
    end

    // Next-state and next-output decode; cfg_we overrides everything else.
    always_comb begin
        mode_d  = mode_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        fail_d  = 1'b0;
        err_d   = 1'b0;

        if (cfg_we) begin
            mode_d  = mode_e'(cfg_mode);
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (mode_q == MODE_CONSEC) begin
            state_d = ST_IDLE;
            if (a) begin
                cnt_d   = cnt_inc;
                match_d = in_range(cnt_inc);
                // Only the step from MAX_REP to MAX_REP+1, so once per run.
                fail_d  = (cnt_q == CNT_MAX);
            end else begin
                cnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        if (frame_end) begin
                            match_d = in_range(cnt_a);
                            fail_d  = !in_range(cnt_a);
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_OPEN;
                            cnt_d   = cnt_a;
                        end
                    end else if (frame_end) begin
                        err_d = 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (frame_start) begin
                        // Restart: the aborted frame produces no verdict.
                        err_d = 1'b1;
                        if (frame_end) begin
                            match_d = in_range(cnt_a);
                            fail_d  = !in_range(cnt_a);
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_a;
                        end
                    end else if (frame_end) begin
                        match_d = in_range(cnt_inc);
                        fail_d  = !in_range(cnt_inc);
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rep_monitor.sv
// Multi-channel repetition monitor: N_CH independent channels plus a
// combined any_match flag.
module rep_monitor
    import rep_monitor_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int MIN_REP = 5,
    parameter int MAX_REP = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [N_CH-1:0] cfg_mode,
    input  logic [N_CH-1:0] a,
    input  logic [N_CH-1:0] frame_start,
    input  logic [N_CH-1:0] frame_end,
    output logic [N_CH-1:0] match,
    output logic [N_CH-1:0] fail,
    output logic [N_CH-1:0] err,
    output logic            any_match
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        rep_monitor_ch #(
            .MIN_REP (MIN_REP),
            .MAX_REP (MAX_REP)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .cfg_we      (cfg_we),
            .cfg_mode    (cfg_mode[i]),
            .a           (a[i]),
            .frame_start (frame_start[i]),
            .frame_end   (frame_end[i]),
            .match       (match[i]),
            .fail        (fail[i]),
            .err         (err[i])
        );
    end

    // OR of already-registered match bits, so no extra latency.
    assign any_match = |match;

endmodule
